// File: rtl/branch_target_buffer.sv
// Purpose: direct-mapped branch target buffer with F->D->E pipeline and EX target-error flag.
// Latency: lookup 0 cycles (combinational), hitD/targetD 1 cycle, training visible next cycle.
// Backpressure: stallD/stallE hold the pipeline registers, flushD/flushE clear them; stallE also blocks training.
// Optional feature: define BTB_PERF_CNT_EN to add saturating hit/error performance counters.
module branch_target_buffer #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        stallE,
  input  logic        flushE,
  output logic        hitF,
  output logic [31:0] targetF,
  output logic        hitD,
  output logic [31:0] targetD,
  input  logic        updE,
  input  logic [31:0] pcE,
  input  logic        actual_takeE,
  input  logic [31:0] actual_targetE,
  output logic        btb_errE
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_err_cnt
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } entry_t;

  entry_t           mem [ENTRIES];
  entry_t           rdEntry;
  entry_t           wrEntry;
  logic [IDX_W-1:0] idxF;
  logic [IDX_W-1:0] idxE;
  logic [TAG_W-1:0] tagF;
  logic [TAG_W-1:0] tagE;
  logic             wrEn;
  logic             hitE;
  logic [31:0]      ptargetE;

  // Byte-offset bits and PC bits above the tag take no part in indexing or matching.
  logic unusedPcBits;
  assign unusedPcBits = ^{pcF[31:IDX_W+TAG_W+2], pcF[1:0], pcE[31:IDX_W+TAG_W+2], pcE[1:0]};

  assign idxF = pcF[IDX_W+1:2];
  assign tagF = pcF[IDX_W+TAG_W+1:IDX_W+2];
  assign idxE = pcE[IDX_W+1:2];
  assign tagE = pcE[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads pre-write contents: no bypass from the same-cycle training write.
  assign rdEntry = mem[idxF];
  assign hitF    = rdEntry.valid & (rdEntry.tag == tagF);
  assign targetF = rdEntry.target;

  // Only taken branches train; a stalled EX instruction will resolve again later.
  assign wrEn              = updE & actual_takeE & ~stallE;
  assign wrEntry.valid     = 1'b1;
  assign wrEntry.tag       = tagE;
  assign wrEntry.target    = actual_targetE;

  // Entry storage: cleared in one reset cycle, overwritten unconditionally on a taken resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[idxE] <= wrEntry;
    end
  end

  // F->D register: flush dominates stall.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      hitD    <= 1'b0;
      targetD <= '0;
    end else if (!stallD) begin
      hitD    <= hitF;
      targetD <= targetF;
    end
  end

  // D->E register: flush dominates stall.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      hitE     <= 1'b0;
      ptargetE <= '0;
    end else if (!stallE) begin
      hitE     <= hitD;
      ptargetE <= targetD;
    end
  end

  // Taken branch that either missed or was predicted to the wrong target.
  assign btb_errE = updE & actual_takeE & (~hitE | (ptargetE != actual_targetE));

`ifdef BTB_PERF_CNT_EN
  // Saturating counters of useful lookups and EX target errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_cnt <= '0;
      perf_err_cnt <= '0;
    end else begin
      if (hitF && !stallD && (perf_hit_cnt != 32'hFFFF_FFFF)) begin
        perf_hit_cnt <= perf_hit_cnt + 32'd1;
      end
      if (btb_errE && (perf_err_cnt != 32'hFFFF_FFFF)) begin
        perf_err_cnt <= perf_err_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed literal cases plus random traffic.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_branch_target_buffer;
  localparam int IDX_W = 6;
  localparam int TAG_W = 8;
  localparam int ENT   = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        stallD, flushD, stallE, flushE;
  logic        hitF, hitD, btb_errE;
  logic [31:0] targetF, targetD;
  logic        updE, actual_takeE;
  logic [31:0] pcE, actual_targetE;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  always #5 clk = ~clk;

  branch_target_buffer #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .pcF(pcF),
    .stallD(stallD), .flushD(flushD), .stallE(stallE), .flushE(flushE),
    .hitF(hitF), .targetF(targetF), .hitD(hitD), .targetD(targetD),
    .updE(updE), .pcE(pcE), .actual_takeE(actual_takeE),
    .actual_targetE(actual_targetE), .btb_errE(btb_errE)
`ifdef BTB_PERF_CNT_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_err_cnt(perf_err_cnt)
`endif
  );

  // ---------------- behavioural model ----------------
  // Each slot remembers the full PC that last trained it and its target.
  bit          mValid [ENT];
  logic [31:0] mPc    [ENT];
  logic [31:0] mTgt   [ENT];
  bit          mHitD, mHitE;
  logic [31:0] mTgtD, mTgtE;
  longint      mHitCnt, mErrCnt;

  function automatic int slotOf(logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int tagOf(logic [31:0] pc);
    return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return mValid[slotOf(pc)] && (tagOf(mPc[slotOf(pc)]) == tagOf(pc));
  endfunction

  function automatic bit modelErr();
    return updE && actual_takeE && (!mHitE || (mTgtE != actual_targetE));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENT; i++) begin
        mValid[i] <= 1'b0;
        mPc[i]    <= 32'd0;
        mTgt[i]   <= 32'd0;
      end
      mHitD <= 1'b0; mTgtD <= 32'd0;
      mHitE <= 1'b0; mTgtE <= 32'd0;
      mHitCnt <= 0;  mErrCnt <= 0;
    end else begin
      if (updE && actual_takeE && !stallE) begin
        mValid[slotOf(pcE)] <= 1'b1;
        mPc[slotOf(pcE)]    <= pcE;
        mTgt[slotOf(pcE)]   <= actual_targetE;
      end
      if (flushE) begin
        mHitE <= 1'b0; mTgtE <= 32'd0;
      end else if (!stallE) begin
        mHitE <= mHitD; mTgtE <= mTgtD;
      end
      if (flushD) begin
        mHitD <= 1'b0; mTgtD <= 32'd0;
      end else if (!stallD) begin
        mHitD <= modelHit(pcF); mTgtD <= mTgt[slotOf(pcF)];
      end
      if (modelHit(pcF) && !stallD && mHitCnt < 64'hFFFF_FFFF) mHitCnt <= mHitCnt + 1;
      if (modelErr() && mErrCnt < 64'hFFFF_FFFF) mErrCnt <= mErrCnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (cmpEn) begin
      chk("m_hitF",    {31'd0, hitF},     {31'd0, modelHit(pcF)});
      chk("m_targetF", targetF,           mTgt[slotOf(pcF)]);
      chk("m_hitD",    {31'd0, hitD},     {31'd0, mHitD});
      chk("m_targetD", targetD,           mTgtD);
      chk("m_errE",    {31'd0, btb_errE}, {31'd0, modelErr()});
`ifdef BTB_PERF_CNT_EN
      chk("m_perfHit", perf_hit_cnt, mHitCnt[31:0]);
      chk("m_perfErr", perf_err_cnt, mErrCnt[31:0]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    stallD = 0; flushD = 0; stallE = 0; flushE = 0;
    updE = 0; actual_takeE = 0; pcE = 0; actual_targetE = 0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt);
    updE = 1; actual_takeE = 1; pcE = pc; actual_targetE = tgt;
  endtask

  initial begin
    rst = 1; pcF = 0; idle();
    nextCycle(); nextCycle();
    rst = 0; cmpEn = 1;

    // Reset state
    pcF = 32'h0040_0010;
    @(negedge clk);
    chk("rst_hitF", {31'd0, hitF}, 32'd0);
    chk("rst_targetF", targetF, 32'd0);
    chk("rst_errE", {31'd0, btb_errE}, 32'd0);
`ifdef BTB_PERF_CNT_EN
    chk("rst_perfHit", perf_hit_cnt, 32'd0);
    chk("rst_perfErr", perf_err_cnt, 32'd0);
`endif
    nextCycle();
    @(negedge clk);
    chk("rst_hitD", {31'd0, hitD}, 32'd0);

    // Train, same-cycle lookup still misses
    nextCycle();
    train(32'h0040_0010, 32'h0040_0100);
    @(negedge clk);
    chk("samecyc_miss", {31'd0, hitF}, 32'd0);
    nextCycle(); idle();
    @(negedge clk);
    chk("train_hitF", {31'd0, hitF}, 32'd1);
    chk("train_targetF", targetF, 32'h0040_0100);

    // Alias: same index, different tag
    train(32'h0040_0110, 32'h0040_0200);
    nextCycle(); idle();
    @(negedge clk);
    chk("alias_old_miss", {31'd0, hitF}, 32'd0);
    nextCycle(); pcF = 32'h0040_0110;
    @(negedge clk);
    chk("alias_new_hit", {31'd0, hitF}, 32'd1);
    chk("alias_new_tgt", targetF, 32'h0040_0200);

    // Carry a hit through D and E, resolve with EX held so the entry stays put
    nextCycle(); train(32'h0040_0010, 32'h0040_0100); pcF = 32'h0040_0010;
    nextCycle(); idle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    chk("carry_hitD", {31'd0, hitD}, 32'd1);
    chk("carry_targetD", targetD, 32'h0040_0100);
    nextCycle(); stallE = 1; train(32'h0040_0010, 32'h0040_0104);
    @(negedge clk);
    chk("err_wrong_tgt", {31'd0, btb_errE}, 32'd1);
    nextCycle(); stallE = 1; train(32'h0040_0010, 32'h0040_0100);
    @(negedge clk);
    chk("err_right_tgt", {31'd0, btb_errE}, 32'd0);
    nextCycle(); idle(); updE = 1; actual_takeE = 0; pcE = 32'h0040_0010;
    actual_targetE = 32'h0040_0300;
    @(negedge clk);
    chk("err_not_taken", {31'd0, btb_errE}, 32'd0);
    nextCycle(); idle();
    @(negedge clk);
    chk("nt_entry_hit", {31'd0, hitF}, 32'd1);
    chk("nt_entry_tgt", targetF, 32'h0040_0100);

    // stallD holds a hit for 3 cycles while fetch misses
    nextCycle(); stallD = 1; pcF = 32'h0000_0800;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stallD_hold", {31'd0, hitD}, 32'd1);
      nextCycle();
    end
    flushD = 1;
    nextCycle(); idle();
    @(negedge clk);
    chk("flushD_wins", {31'd0, hitD}, 32'd0);

    // flushE clears the carried hit
    nextCycle(); pcF = 32'h0040_0010;
    nextCycle();
    nextCycle(); flushE = 1;
    nextCycle(); idle(); stallE = 1; train(32'h0040_0010, 32'h0040_0100);
    @(negedge clk);
    chk("flushE_err", {31'd0, btb_errE}, 32'd1);
    nextCycle(); idle();

    // Random traffic over a small PC pool so hits, aliases and errors all occur
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pcA, pcB;
      pcA = 32'h0040_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)
            | $urandom_range(0, 3);
      pcB = 32'h0040_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      pcF            = pcA;
      rst            = ($urandom_range(0, 299) == 0);
      stallD         = ($urandom_range(0, 5) == 0);
      flushD         = ($urandom_range(0, 9) == 0);
      stallE         = ($urandom_range(0, 5) == 0);
      flushE         = ($urandom_range(0, 9) == 0);
      updE           = ($urandom_range(0, 2) != 0);
      actual_takeE   = ($urandom_range(0, 3) != 0);
      pcE            = pcB;
      actual_targetE = 32'h0000_1000 << $urandom_range(0, 2);
      nextCycle();
    end
    rst = 0; idle();
    nextCycle();

`ifdef BTB_PERF_CNT_EN
    // Counter reset
    rst = 1;
    nextCycle(); rst = 0;
    @(negedge clk);
    chk("perf_clr_hit", perf_hit_cnt, 32'd0);
    chk("perf_clr_err", perf_err_cnt, 32'd0);
`endif

    cmpEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer beside the IF-stage direction predictor. Supplies a predicted target for the fetch PC, carries hit/target through the D and E pipeline registers alongside the direction prediction, and flags a target error in EX. It is trained from EX-resolved taken branches. The next-PC mux uses `targetD` when the D-stage direction prediction is taken and `hitD` is set, and redirects on `btb_errE`.

## Interface
Parameters:
- `IDX_W`, default 6: index width; the buffer holds 2^IDX_W entries.
- `TAG_W`, default 8: stored tag width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pcF` in 32: fetch PC.
- `stallD` in 1: hold the F→D register.
- `flushD` in 1: clear the F→D register.
- `stallE` in 1: hold the D→E register.
- `flushE` in 1: clear the D→E register.
- `hitF` out 1: combinational lookup hit.
- `targetF` out 32: combinational stored target.
- `hitD` out 1: registered hit in D.
- `targetD` out 32: registered target in D.
- `updE` in 1: the EX instruction is a resolved branch or jump.
- `pcE` in 32: PC of the EX branch.
- `actual_takeE` in 1: the EX branch was taken.
- `actual_targetE` in 32: resolved target.
- `btb_errE` out 1: the EX branch was taken but the buffer missed or gave a wrong target.
- `perf_hit_cnt` out 32: present only with `BTB_PERF_CNT_EN`.
- `perf_err_cnt` out 32: present only with `BTB_PERF_CNT_EN`.

## Operation
Index and tag:
- index = `pc[IDX_W+1:2]`.
- tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`.
- Bits [1:0] are ignored.

Entry contents: `valid`, tag[TAG_W], target[32].

Lookup (F):
- `hitF` = valid[idxF] & (tag[idxF] == tagF).
- `targetF` = target[idxF] regardless of hit.
- `targetF` is don't-care when `hitF`=0, but it must never be X after reset; reset clears targets to 0.

F→D register:
- rst or flushD → `hitD`=0, `targetD`=0.
- Otherwise, when ~stallD: `hitD`←`hitF`, `targetD`←`targetF`.
- Otherwise hold.
- flushD wins over stallD.

D→E register (internal `hitE`, `ptargetE`):
- rst or flushE → 0.
- Otherwise, when ~stallE: load from D.
- flushE wins over stallE.

Error:
- `btb_errE` = updE & actual_takeE & (~hitE | ptargetE != actual_targetE).
- Combinational from registered state and inputs.
- Not-taken branches never raise it.

Update (end of cycle, when updE & actual_takeE & ~stallE):
- Write entry idx(pcE): valid=1, tag(pcE), `actual_targetE`.
- Direct-mapped: a different tag overwrites unconditionally.
- updE & ~actual_takeE does not modify the entry; direction comes from the direction predictor.

Reset:
- All valid bits cleared in the single reset cycle. Targets and tags are also cleared.
- Reset mid-operation discards all entries and pipeline state.

Same-index read/write in one cycle:
- The lookup returns the pre-write contents; there is no bypass.
- The new contents are visible from the next cycle.

## Timing
- Lookup: 0-cycle combinational from `pcF`.
- `hitD`/`targetD`: 1 cycle after F (unless stalled).
- Error: `btb_errE` is valid in the same cycle as `updE`.
- Training latency: a write in cycle N is visible to a lookup in cycle N+1.

Reset values:
- `hitF`=0 (all invalid).
- `targetF`=0.
- `hitD`=0, `targetD`=0.
- `btb_errE`=0.
- Perf counters = 0.

## Configuration
`BTB_PERF_CNT_EN`:
- When defined:
  - `perf_hit_cnt` increments each cycle with hitF & ~stallD.
  - `perf_err_cnt` increments each cycle with `btb_errE`.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: the counters and both ports are absent; all other behaviour is identical.

## Test plan
- Reset, then `pcF`=0x0040_0010 → `hitF`=0, `targetF`=0; one cycle later `hitD`=0.
- updE=1, actual_takeE=1, pcE=0x0040_0010, actual_targetE=0x0040_0100 → next cycle `pcF`=0x0040_0010 gives `hitF`=1, `targetF`=0x0040_0100. A same-cycle lookup of that PC still misses.
- Alias check: write pcE=0x0040_0010 with target 0x0040_0100, then write pcE=0x0040_0110 (same index, different tag) with target 0x0040_0200 → lookup of 0x0040_0010 misses; lookup of 0x0040_0110 hits with 0x0040_0200.
- Carry a hit through D→E with ptarget 0x0040_0100:
  - Resolve with actual_targetE=0x0040_0104 → `btb_errE`=1.
  - Resolve with 0x0040_0100 → 0.
  - Resolve with actual_takeE=0 → 0, entry unchanged.
- Stall/flush: stallD=1 holds `hitD`=1 for 3 cycles despite `pcF` changing to a miss; flushD=1 together with stallD=1 → `hitD`=0 next cycle. flushE likewise zeroes `hitE`, so a taken updE then gives `btb_errE`=1.
- With `BTB_PERF_CNT_EN`: 5 hitting unstalled fetches and 2 errors → `perf_hit_cnt`=5, `perf_err_cnt`=2; rst → both 0.
